// File: rtl/keypad_scan.sv
`default_nettype none
// ============================================================================
// Module  : keypad_scan
// Brief   : 4x4 active-low matrix keypad scanner with tick-paced press/release
//           debounce, one-clock key_valid pulse and key_held level.
// Rev     : 1.0
// ============================================================================
module keypad_scan #(
    parameter int SCAN_DIV  = 49_999,
    parameter int DEB_TICKS = 20
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DIV_W = (SCAN_DIV < 1) ? 1 : $clog2(SCAN_DIV + 1);
    localparam int CNT_W = (DEB_TICKS < 1) ? 1 : $clog2(DEB_TICKS + 1);

    localparam logic [DIV_W-1:0] c_DIV_TC   = DIV_W'(SCAN_DIV);
    localparam logic [CNT_W-1:0] c_DEB_MAX  = CNT_W'(DEB_TICKS);
    localparam logic [CNT_W-1:0] c_DEB_LAST = CNT_W'((DEB_TICKS < 1) ? 0 : DEB_TICKS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DEB   = 2'd2,
        ST_PRESS = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [DIV_W-1:0] r_div;
    logic             w_tick;
    logic [3:0]       r_col_meta;
    logic [3:0]       r_col_s;
    logic [1:0]       r_row;
    logic [1:0]       w_row_nxt;
    logic [1:0]       r_col;
    logic [1:0]       w_col_nxt;
    logic [3:0]       r_pat;
    logic [3:0]       w_pat_nxt;
    logic [CNT_W-1:0] r_deb_cnt;
    logic [CNT_W-1:0] w_deb_nxt;
    logic [CNT_W-1:0] r_rel_cnt;
    logic [CNT_W-1:0] w_rel_nxt;
    logic [3:0]       r_row_out;
    logic [3:0]       w_row_out_nxt;
    logic [3:0]       r_key_code;
    logic [3:0]       w_code_nxt;
    logic             r_key_valid;
    logic             w_valid_nxt;
    logic             r_key_held;
    logic             w_held_nxt;
    logic [2:0]       w_zeros;
    logic [1:0]       w_cidx;
    logic             w_single;

    assign w_tick = (r_div == c_DIV_TC);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    // Columns idle high, so the synchronizer resets to "no key".
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_col_meta <= 4'hF;
            r_col_s    <= 4'hF;
        end else begin
            r_col_meta <= col_in;
            r_col_s    <= r_col_meta;
        end
    end

    always_comb begin
        w_zeros = 3'd0;
        w_cidx  = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!r_col_s[i]) begin
                w_zeros = w_zeros + 3'd1;
                w_cidx  = 2'(i);
            end
        end
    end

    assign w_single = (w_zeros == 3'd1);

    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        w_pat_nxt   = r_pat;
        w_deb_nxt   = r_deb_cnt;
        w_rel_nxt   = r_rel_cnt;
        w_code_nxt  = r_key_code;
        w_valid_nxt = 1'b0;

        if (w_tick) begin
            case (r_state)
                ST_IDLE: begin
                    if (r_col_s != 4'hF) begin
                        w_state_nxt = ST_SCAN;
                        w_row_nxt   = 2'd0;
                    end
                end
                ST_SCAN: begin
                    // Multi-column patterns fall through as "no key in this row".
                    if (w_single) begin
                        w_state_nxt = ST_DEB;
                        w_col_nxt   = w_cidx;
                        w_pat_nxt   = r_col_s;
                        w_deb_nxt   = CNT_W'(1);
                    end else if (r_row == 2'd3) begin
                        w_state_nxt = ST_IDLE;
                        w_row_nxt   = 2'd0;
                    end else begin
                        w_row_nxt   = r_row + 2'd1;
                    end
                end
                ST_DEB: begin
                    if (r_col_s == r_pat) begin
                        if (r_deb_cnt >= c_DEB_LAST) begin
                            w_state_nxt = ST_PRESS;
                            w_deb_nxt   = c_DEB_MAX;
                            w_rel_nxt   = '0;
                            w_code_nxt  = {r_row, r_col};
                            w_valid_nxt = 1'b1;
                        end else begin
                            w_deb_nxt   = r_deb_cnt + CNT_W'(1);
                        end
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_row_nxt   = 2'd0;
                        w_deb_nxt   = '0;
                    end
                end
                ST_PRESS: begin
                    if (r_col_s == 4'hF) begin
                        if (r_rel_cnt >= c_DEB_LAST) begin
                            w_state_nxt = ST_IDLE;
                            w_row_nxt   = 2'd0;
                            w_rel_nxt   = '0;
                            w_deb_nxt   = '0;
                        end else begin
                            w_rel_nxt   = r_rel_cnt + CNT_W'(1);
                        end
                    end else begin
                        w_rel_nxt = '0;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end

        if (w_state_nxt == ST_IDLE) begin
            w_row_out_nxt = 4'b0000;
        end else begin
            w_row_out_nxt = ~(4'b0001 << w_row_nxt);
        end
        w_held_nxt = (w_state_nxt == ST_PRESS);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_IDLE;
            r_row       <= 2'd0;
            r_col       <= 2'd0;
            r_pat       <= 4'hF;
            r_deb_cnt   <= '0;
            r_rel_cnt   <= '0;
            r_row_out   <= 4'b0000;
            r_key_code  <= 4'h0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_row       <= w_row_nxt;
            r_col       <= w_col_nxt;
            r_pat       <= w_pat_nxt;
            r_deb_cnt   <= w_deb_nxt;
            r_rel_cnt   <= w_rel_nxt;
            r_row_out   <= w_row_out_nxt;
            r_key_code  <= w_code_nxt;
            r_key_valid <= w_valid_nxt;
            r_key_held  <= w_held_nxt;
        end
    end

    assign row_out   = r_row_out;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;

endmodule
`default_nettype wire
